// File: rtl/timer_countdown_bcd.sv
// Keypad-loaded 4-digit BCD MM:SS cook timer that counts down on 1 Hz ticks while cooking.
// Optional feature macro: TIMER_NORMALIZE_EN (normalizes seconds 60..99 on entry to COUNT).
module timer_countdown_bcd #(
    parameter int SEC_TENS_WRAP = 5,
    parameter int MIN_TENS_MAX  = 9
) (
    input  logic       clock_100Hz,
    input  logic       reset,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       pgt_1Hz,
    input  logic       enablen,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       zero,
    output logic       counting,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] sec_wrap = 4'(SEC_TENS_WRAP);
    localparam logic [3:0] min_tens_max = 4'(MIN_TENS_MAX);

    state_t     state;
    logic       loadn_q;
    logic       pgt_q;
    logic       load_evt;
    logic       tick_evt;
    logic [3:0] dec_so, dec_st, dec_mo, dec_mt;
    logic       dec_zero;
    logic [3:0] entry_mt;

    assign load_evt = loadn_q & ~loadn;
    assign tick_evt = ~pgt_q & pgt_1Hz;
    assign zero     = (sec_ones == 4'd0) && (sec_tens == 4'd0) &&
                      (min_ones == 4'd0) && (min_tens == 4'd0);
    assign counting = (state == COUNT);
    assign entry_mt = (min_ones > min_tens_max) ? min_tens_max : min_ones;

    // One-second BCD decrement with borrow ripple; seconds-tens wraps to SEC_TENS_WRAP.
    always_comb begin
        dec_so = sec_ones;
        dec_st = sec_tens;
        dec_mo = min_ones;
        dec_mt = min_tens;
        if (sec_ones != 4'd0) begin
            dec_so = sec_ones - 4'd1;
        end else begin
            dec_so = 4'd9;
            if (sec_tens != 4'd0) begin
                dec_st = sec_tens - 4'd1;
            end else begin
                dec_st = sec_wrap;
                if (min_ones != 4'd0) begin
                    dec_mo = min_ones - 4'd1;
                end else begin
                    dec_mo = 4'd9;
                    dec_mt = min_tens - 4'd1;
                end
            end
        end
        dec_zero = (dec_so == 4'd0) && (dec_st == 4'd0) &&
                   (dec_mo == 4'd0) && (dec_mt == 4'd0);
    end

`ifdef TIMER_NORMALIZE_EN
    logic [3:0] norm_so, norm_st, norm_mo, norm_mt;

    // Seconds 60..99 become one more minute; at 99 minutes there is nowhere to carry, so clamp.
    always_comb begin
        norm_so = sec_ones;
        norm_st = sec_tens;
        norm_mo = min_ones;
        norm_mt = min_tens;
        if (sec_tens >= 4'd6) begin
            if ((min_tens == 4'd9) && (min_ones == 4'd9)) begin
                norm_st = 4'd5;
                norm_so = 4'd9;
            end else begin
                norm_st = sec_tens - 4'd6;
                if (min_ones == 4'd9) begin
                    norm_mo = 4'd0;
                    norm_mt = min_tens + 4'd1;
                end else begin
                    norm_mo = min_ones + 4'd1;
                end
            end
        end
    end
`endif

    always_ff @(posedge clock_100Hz) begin
        if (reset) begin
            state    <= IDLE;
            loadn_q  <= 1'b1;
            pgt_q    <= 1'b1;
            done     <= 1'b0;
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
        end else begin
            loadn_q <= loadn;
            pgt_q   <= pgt_1Hz;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!enablen) begin
                        if (!zero) begin
                            state <= COUNT;
`ifdef TIMER_NORMALIZE_EN
                            sec_ones <= norm_so;
                            sec_tens <= norm_st;
                            min_ones <= norm_mo;
                            min_tens <= norm_mt;
`endif
                        end
                    end else if (load_evt && (D <= 4'd9)) begin
                        min_tens <= entry_mt;
                        min_ones <= sec_tens;
                        sec_tens <= sec_ones;
                        sec_ones <= D;
                    end
                end
                COUNT: begin
                    if (enablen) begin
                        state <= IDLE;
                    end else if (tick_evt && !zero) begin
                        sec_ones <= dec_so;
                        sec_tens <= dec_st;
                        min_ones <= dec_mo;
                        min_tens <= dec_mt;
                        if (dec_zero) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (enablen) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
